// File: rtl/csa_seq_pkg.sv
// -----------------------------------------------------------------------------
// csa_seq_pkg
// Shared definitions for the carry-save sum sequencer: default operand and
// accumulator widths, the largest operand count a job may request, and the
// sequencer state encoding.
// -----------------------------------------------------------------------------
package csa_seq_pkg;

   localparam int DEF_W     = 32;
   localparam int DEF_ACC_W = DEF_W + 4;   // 4 guard bits hold the sum of 15 operands
   localparam int MAX_COUNT = 15;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      RESOLVE = 2'd2,
      DONE    = 2'd3
   } state_e;

endpackage

// File: rtl/csa_3to2.sv
// -----------------------------------------------------------------------------
// csa_3to2
// Bitwise 3:2 carry-save compressor. Reduces three WIDTH-bit vectors to a sum
// vector and a carry vector such that a + b + c == sum + (carry << 1).
// The carry is returned unshifted; the caller applies the weight shift.
//
// Ports
//   a, b, c : input  [WIDTH-1:0]  operands
//   sum     : output [WIDTH-1:0]  bitwise XOR of the three operands
//   carry   : output [WIDTH-1:0]  bitwise majority, not yet shifted
// -----------------------------------------------------------------------------
module csa_3to2 #(
   parameter int WIDTH = 36
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry
);

   assign sum   = a ^ b ^ c;
   assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_sum_sequencer.sv
// -----------------------------------------------------------------------------
// csa_sum_sequencer
// Accumulates a job of 1..15 unsigned operands in carry-save form (one 3:2
// compression per accepted operand), resolves the redundant pair with a single
// carry-propagate add, and presents the sum until it is handshaken.
//
// Ports
//   clk       : input              rising-edge clock
//   rst       : input              asynchronous active-high reset
//   start     : input              begin a job (only looked at in IDLE)
//   count     : input  [3:0]       operands in the job, sampled with start
//   in_valid  : input              operand present on in_data
//   in_data   : input  [W-1:0]     unsigned operand
//   in_ready  : output             high while operands are being accepted
//   out_valid : output             result present on out_data
//   out_data  : output [ACC_W-1:0] sum of the job's operands (mod 2^ACC_W)
//   out_ready : input              result consumed when out_valid is high
//   busy      : output             high whenever a job is in progress
//   err       : output             one-cycle pulse for a start with count==0
// -----------------------------------------------------------------------------
module csa_sum_sequencer
   import csa_seq_pkg::*;
#(
   parameter int W     = DEF_W,
   parameter int ACC_W = W + 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       count,
   input  logic             in_valid,
   input  logic [W-1:0]     in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [ACC_W-1:0] out_data,
   input  logic             out_ready,
   output logic             busy,
   output logic             err
);

   state_e             state_q, state_d;
   logic [ACC_W-1:0]   s_q, s_d;
   logic [ACC_W-1:0]   c_q, c_d;
   logic [3:0]         rem_q, rem_d;
   logic [ACC_W-1:0]   out_data_q, out_data_d;
   logic               err_q, err_d;

   logic [ACC_W-1:0]   x_ext_s;
   logic [ACC_W-1:0]   csa_sum_s;
   logic [ACC_W-1:0]   csa_carry_s;

   assign x_ext_s = ACC_W'(in_data);

   csa_3to2 #(
      .WIDTH (ACC_W)
   ) u_csa (
      .a     (s_q),
      .b     (c_q),
      .c     (x_ext_s),
      .sum   (csa_sum_s),
      .carry (csa_carry_s)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers: carry-save pair, operand countdown, result, error pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_q        <= {ACC_W{1'b0}};
         c_q        <= {ACC_W{1'b0}};
         rem_q      <= 4'd0;
         out_data_q <= {ACC_W{1'b0}};
         err_q      <= 1'b0;
      end else begin
         s_q        <= s_d;
         c_q        <= c_d;
         rem_q      <= rem_d;
         out_data_q <= out_data_d;
         err_q      <= err_d;
      end
   end

   // Next-state and datapath update logic.
   always_comb begin
      state_d    = state_q;
      s_d        = s_q;
      c_d        = c_q;
      rem_d      = rem_q;
      out_data_d = out_data_q;
      err_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (count != 4'd0) begin
                  state_d = ACCUM;
                  rem_d   = count;
                  s_d     = {ACC_W{1'b0}};
                  c_d     = {ACC_W{1'b0}};
               end else begin
                  err_d   = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end

         ACCUM: begin
            if (in_valid) begin
               s_d   = csa_sum_s;
               // Majority bits carry weight 2; bits shifted past ACC_W are dropped (mod 2^ACC_W).
               c_d   = csa_carry_s << 1'b1;
               rem_d = rem_q - 4'd1;
               if (rem_q == 4'd1) begin
                  state_d = RESOLVE;
               end else begin
                  state_d = ACCUM;
               end
            end else begin
               state_d = ACCUM;
            end
         end

         RESOLVE: begin
            out_data_d = s_q + c_q;
            state_d    = DONE;
         end

         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Handshake and status outputs decoded from the current state.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state_q)
         IDLE:    busy      = 1'b0;
         ACCUM:   in_ready  = 1'b1;
         RESOLVE: in_ready  = 1'b0;
         DONE:    out_valid = 1'b1;
         default: busy      = 1'b0;
      endcase
   end

   assign out_data = out_data_q;
   assign err      = err_q;

endmodule

// File: tb/tb_csa_sum_sequencer.sv
// -----------------------------------------------------------------------------
// tb_csa_sum_sequencer
// Self-checking bench for csa_sum_sequencer. Expected sums are plain integer
// additions of the job's operands truncated to ACC_W bits.
// -----------------------------------------------------------------------------
module tb_csa_sum_sequencer;

   localparam int W     = 32;
   localparam int ACC_W = 36;

   logic             clk;
   logic             rst;
   logic             start;
   logic [3:0]       count;
   logic             in_valid;
   logic [W-1:0]     in_data;
   logic             in_ready;
   logic             out_valid;
   logic [ACC_W-1:0] out_data;
   logic             out_ready;
   logic             busy;
   logic             err;

   int n_checks;
   int n_fails;

   logic [W-1:0] ops [0:14];

   csa_sum_sequencer #(
      .W     (W),
      .ACC_W (ACC_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .count     (count),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .busy      (busy),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Runs one job over ops[0..cnt-1]. Entered and left at 1 time unit after a rising edge.
   task automatic run_job(input int cnt, input int max_gap, input int hold,
                          input bit poke_start, input string tag);
      logic [ACC_W-1:0] exp_sum;
      int gaps;
      exp_sum = '0;
      for (int i = 0; i < cnt; i++) exp_sum = exp_sum + ACC_W'(ops[i]);

      start = 1'b1;
      count = 4'(cnt);
      @(posedge clk); #1;
      start = 1'b0;
      check_eq({tag, ".busy_start"}, 64'(busy), 64'd1);

      for (int i = 0; i < cnt; i++) begin
         gaps = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         repeat (gaps) begin
            in_valid = 1'b0;
            if (poke_start) begin
               start = 1'b1;
               count = 4'd0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            check_eq({tag, ".gap_err"}, 64'(err), 64'd0);
         end
         in_valid = 1'b1;
         in_data  = ops[i];
         check_eq({tag, ".in_ready"}, 64'(in_ready), 64'd1);
         check_eq({tag, ".accum_ov"}, 64'(out_valid), 64'd0);
         @(posedge clk); #1;
         in_valid = 1'b0;
         in_data  = W'($urandom());
      end

      check_eq({tag, ".resolve_ov"}, 64'(out_valid), 64'd0);
      check_eq({tag, ".resolve_ir"}, 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      check_eq({tag, ".ov"}, 64'(out_valid), 64'd1);
      check_eq({tag, ".data"}, 64'(out_data), 64'(exp_sum));

      out_ready = 1'b0;
      repeat (hold) begin
         if (poke_start) begin
            start = 1'b1;
            count = 4'(cnt);
         end
         @(posedge clk); #1;
         start = 1'b0;
         check_eq({tag, ".hold_ov"}, 64'(out_valid), 64'd1);
         check_eq({tag, ".hold_data"}, 64'(out_data), 64'(exp_sum));
         check_eq({tag, ".hold_err"}, 64'(err), 64'd0);
      end

      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_eq({tag, ".post_ov"}, 64'(out_valid), 64'd0);
      check_eq({tag, ".post_busy"}, 64'(busy), 64'd0);
      check_eq({tag, ".post_err"}, 64'(err), 64'd0);
   endtask

   initial begin
      int cnt;
      int mode;
      n_checks  = 0;
      n_fails   = 0;
      rst       = 1'b1;
      start     = 1'b0;
      count     = 4'd0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst.out_valid", 64'(out_valid), 64'd0);
      check_eq("rst.in_ready",  64'(in_ready),  64'd0);
      check_eq("rst.busy",      64'(busy),      64'd0);
      check_eq("rst.err",       64'(err),       64'd0);
      check_eq("rst.out_data",  64'(out_data),  64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic job: 10 + 2 + 15
      ops[0] = 32'd10; ops[1] = 32'd2; ops[2] = 32'd15;
      run_job(3, 0, 0, 1'b0, "basic");

      // Back-to-back jobs
      ops[0] = 32'd5;   ops[1] = 32'd7;   ops[2] = 32'd8;
      run_job(3, 0, 1, 1'b0, "b2b0");
      ops[0] = 32'd20;  ops[1] = 32'd30;  ops[2] = 32'd25;
      run_job(3, 0, 2, 1'b0, "b2b1");
      ops[0] = 32'd123; ops[1] = 32'd234; ops[2] = 32'd345;
      run_job(3, 0, 0, 1'b0, "b2b2");

      // Maximum job of all-ones operands with gapped input
      for (int i = 0; i < 15; i++) ops[i] = 32'hFFFF_FFFF;
      run_job(15, 1, 0, 1'b1, "max15");

      // Stalled consumer with start pulses in DONE
      ops[0] = 32'd50; ops[1] = 32'd100;
      run_job(2, 0, 3, 1'b1, "stall");

      // count==0 start raises a single-cycle err
      start = 1'b1;
      count = 4'd0;
      @(posedge clk); #1;
      start = 1'b0;
      check_eq("err.pulse", 64'(err),  64'd1);
      check_eq("err.busy",  64'(busy), 64'd0);
      @(posedge clk); #1;
      check_eq("err.clear", 64'(err),  64'd0);
      check_eq("err.busy2", 64'(busy), 64'd0);

      // Reset after two of four operands
      start = 1'b1;
      count = 4'd4;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_data  = W'($urandom());
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_eq("midrst.out_valid", 64'(out_valid), 64'd0);
      check_eq("midrst.in_ready",  64'(in_ready),  64'd0);
      check_eq("midrst.busy",      64'(busy),      64'd0);
      check_eq("midrst.err",       64'(err),       64'd0);
      check_eq("midrst.out_data",  64'(out_data),  64'd0);
      @(posedge clk); #3;
      rst = 1'b0;
      repeat (6) begin
         in_valid = 1'b1;
         in_data  = W'($urandom());
         @(posedge clk); #1;
         check_eq("midrst.no_result", 64'(out_valid), 64'd0);
         check_eq("midrst.idle",      64'(busy),      64'd0);
      end
      in_valid = 1'b0;
      ops[0] = 32'd7;
      run_job(1, 0, 0, 1'b0, "after_rst");

      // Randomized jobs
      for (int j = 0; j < 25; j++) begin
         cnt  = int'($urandom_range(15, 1));
         mode = int'($urandom_range(2, 0));
         for (int i = 0; i < cnt; i++) begin
            if (mode == 0)      ops[i] = W'($urandom());
            else if (mode == 1) ops[i] = 32'hFFFF_FFFF - W'($urandom_range(3, 0));
            else                ops[i] = W'($urandom_range(255, 0));
         end
         run_job(cnt, int'($urandom_range(2, 0)), int'($urandom_range(3, 0)),
                 1'($urandom_range(1, 0)), "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
